// File: rtl/mem_port_arbiter.sv
// Shared instruction/data memory port arbiter.
// Fetch vs load/store arbitration, 1-cycle read response, halt on illegal address.
module mem_port_arbiter #(
    parameter int ADDR_BITS  = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic [31:0] err_addr
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    localparam logic [3:0] LP_SMAX = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_starve;
    logic        w_run;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_accept;
    logic [31:0] w_acc_addr;
    logic        w_legal;

    function automatic logic f_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:ADDR_BITS] == '0);
    endfunction

    // Arbitration: data wins unless fetch has been starved STARVE_MAX times.
    always_comb begin
        w_run      = (r_state == S_RUN);
        w_grant_i  = w_run & if_req & (~d_req | (r_starve == LP_SMAX));
        w_grant_d  = w_run & d_req & ~w_grant_i;
        w_accept   = w_grant_i | w_grant_d;
        w_acc_addr = w_grant_d ? d_addr : if_addr;
        w_legal    = f_legal(w_acc_addr);
    end

    // Memory-side drive and handshake outputs.
    always_comb begin
        if_ready  = w_grant_i;
        d_ready   = w_grant_d;
        mem_addr  = w_acc_addr;
        mem_wdata = d_wdata;
        mem_wr_en = w_grant_d & d_we & f_legal(d_addr) & ~reset;
    end

    // Next state: an accepted illegal access halts the port until reset.
    always_comb begin
        w_next_state = r_state;
        if (w_run && w_accept && !w_legal) begin
            w_next_state = S_HALT;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fetch starvation counter, saturating at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= 4'd0;
        end else if (w_grant_i || !if_req) begin
            r_starve <= 4'd0;
        end else if (w_grant_d && (r_starve != LP_SMAX)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Registered read responses; rdata holds until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
        end else begin
            if_rvalid <= w_grant_i & w_legal;
            d_rvalid  <= w_grant_d & w_legal;
            if (w_grant_i && w_legal) begin
                if_rdata <= mem_rdata;
            end
            if (w_grant_d && w_legal) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    // Sticky error flag capturing the first offending address.
    always_ff @(posedge clk) begin
        if (reset) begin
            err      <= 1'b0;
            err_addr <= 32'd0;
        end else if (w_accept && !w_legal && !err) begin
            err      <= 1'b1;
            err_addr <= w_acc_addr;
        end
    end

endmodule
